// File: rtl/fifo_request_arbiter_pkg.sv
// Shared definitions for fifo_request_arbiter: FSM state encoding and the
// index-width helper used to size the grant index.
package fifo_request_arbiter_pkg;

  typedef enum logic {
    ARB_STATE_IDLE  = 1'b0,
    ARB_STATE_ISSUE = 1'b1
  } arb_state_t;

  localparam int PERF_CTR_WIDTH_IN_BITS = 32;

  // Ceiling log2, minimum 1 so a 2-requester arbiter still gets a 1-bit index.
  function automatic int arb_clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_request_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin selector that returns the first
// set request bit scanning upward from last_grant+1, wrapping modulo the width.
module rr_priority_picker #(
  parameter int NUM_REQUESTERS              = 4,
  parameter int REQUESTER_IDX_WIDTH_IN_BITS = 2
) (
  input  logic [NUM_REQUESTERS-1:0]              request_vec,
  input  logic [REQUESTER_IDX_WIDTH_IN_BITS-1:0] last_grant,
  output logic [REQUESTER_IDX_WIDTH_IN_BITS-1:0] grant_idx,
  output logic                                   grant_valid
);

  logic [REQUESTER_IDX_WIDTH_IN_BITS-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int offset = NUM_REQUESTERS; offset >= 1; offset--) begin
      cand = REQUESTER_IDX_WIDTH_IN_BITS'((int'(last_grant) + offset) % NUM_REQUESTERS);
      if (request_vec[cand]) begin
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_request_arbiter.sv
// Round-robin arbiter sharing one fifo_queue write port among NUM_REQUESTERS
// producers. Optional per-producer grant counters: FIFO_ARB_PERF_CTR_EN.
module fifo_request_arbiter
  import fifo_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS              = 4,
  parameter int REQUESTER_IDX_WIDTH_IN_BITS = arb_clog2(NUM_REQUESTERS),
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS  = 32
) (
  input  logic                                                 clk_in,
  input  logic                                                 reset_in,
  input  logic [NUM_REQUESTERS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
  input  logic [NUM_REQUESTERS-1:0]                            request_valid_packed_in,
  output logic [NUM_REQUESTERS-1:0]                            issue_ack_packed_out,
  input  logic                                                 fifo_full_in,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                request_out,
  output logic                                                 request_valid_out,
  input  logic                                                 issue_ack_in,
  output logic [REQUESTER_IDX_WIDTH_IN_BITS-1:0]               grant_idx_out
`ifdef FIFO_ARB_PERF_CTR_EN
  ,
  output logic [NUM_REQUESTERS*PERF_CTR_WIDTH_IN_BITS-1:0]     grant_count_packed_out
`endif
);

  localparam int IDX_W = REQUESTER_IDX_WIDTH_IN_BITS;
  localparam int ENT_W = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam logic [IDX_W-1:0] LAST_GRANT_INIT = IDX_W'(NUM_REQUESTERS - 1);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  last_grant, last_grant_nxt;
  logic [IDX_W-1:0]  grant_idx_nxt;
  logic [ENT_W-1:0]  request_nxt;
  logic              request_valid_nxt;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [ENT_W-1:0]  picked_entry;

  rr_priority_picker #(
    .NUM_REQUESTERS              (NUM_REQUESTERS),
    .REQUESTER_IDX_WIDTH_IN_BITS (IDX_W)
  ) u_picker (
    .request_vec (request_valid_packed_in),
    .last_grant  (last_grant),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  always_comb begin
    picked_entry = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (pick_idx == IDX_W'(k)) picked_entry = request_packed_in[k*ENT_W +: ENT_W];
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state             <= ARB_STATE_IDLE;
      request_out       <= '0;
      request_valid_out <= 1'b0;
      grant_idx_out     <= '0;
      last_grant        <= LAST_GRANT_INIT;
    end else begin
      state             <= state_nxt;
      request_out       <= request_nxt;
      request_valid_out <= request_valid_nxt;
      grant_idx_out     <= grant_idx_nxt;
      last_grant        <= last_grant_nxt;
    end
  end

  // The granted entry is latched once and held; producer-side changes while
  // in ISSUE (including a premature valid drop) are deliberately ignored.
  always_comb begin
    state_nxt         = state;
    request_nxt       = request_out;
    request_valid_nxt = request_valid_out;
    grant_idx_nxt     = grant_idx_out;
    last_grant_nxt    = last_grant;
    case (state)
      ARB_STATE_IDLE: begin
        if (pick_valid && !fifo_full_in) begin
          request_nxt       = picked_entry;
          request_valid_nxt = 1'b1;
          grant_idx_nxt     = pick_idx;
          state_nxt         = ARB_STATE_ISSUE;
        end else begin
          request_nxt       = '0;
          request_valid_nxt = 1'b0;
        end
      end
      ARB_STATE_ISSUE: begin
        if (issue_ack_in) begin
          last_grant_nxt    = grant_idx_out;
          request_valid_nxt = 1'b0;
          request_nxt       = '0;
          state_nxt         = ARB_STATE_IDLE;
        end
      end
      default: begin
        state_nxt = ARB_STATE_IDLE;
      end
    endcase
  end

  // Ack is steered in the fifo's accept cycle; acks seen in IDLE are stray.
  always_comb begin
    issue_ack_packed_out = '0;
    if (issue_ack_in && (state == ARB_STATE_ISSUE)) begin
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
        if (grant_idx_out == IDX_W'(k)) issue_ack_packed_out[k] = 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_PERF_CTR_EN
  logic [PERF_CTR_WIDTH_IN_BITS-1:0] grant_count [NUM_REQUESTERS];

  always_ff @(posedge clk_in) begin
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (reset_in) begin
        grant_count[k] <= '0;
      end else if (issue_ack_packed_out[k]) begin
        grant_count[k] <= grant_count[k] + PERF_CTR_WIDTH_IN_BITS'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      grant_count_packed_out[k*PERF_CTR_WIDTH_IN_BITS +: PERF_CTR_WIDTH_IN_BITS] = grant_count[k];
    end
  end
`endif

endmodule
